// File: rtl/mem_wb_if.sv
// ---------------------------------------------------------------------------
// mem_wb_if
//   Bundles the EX/MEM register outputs consumed by the memory stage and the
//   MEM/WB writeback signals it produces.
//
//   Signals (named from the memory stage's point of view):
//     result_in           ALU result, or store data for stores
//     reg_addr_in         destination register
//     mem_addr_in         data memory address
//     write_enable_in     register writeback requested
//     store_enable_in     memory store
//     load_enable_in      memory load
//     stall_out           high while a load is outstanding; upstream holds
//     wb_data_out         writeback data
//     wb_reg_addr_out     writeback register
//     wb_write_enable_out register file write strobe
//     wb_valid_out        an operation retired this cycle
//
//   Modports: master = upstream pipeline driving the stage,
//             slave  = the memory/writeback stage itself.
// ---------------------------------------------------------------------------
interface mem_wb_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] result_in;
    logic [3:0]            reg_addr_in;
    logic [ADDR_WIDTH-1:0] mem_addr_in;
    logic                  write_enable_in;
    logic                  store_enable_in;
    logic                  load_enable_in;
    logic                  stall_out;
    logic [DATA_WIDTH-1:0] wb_data_out;
    logic [3:0]            wb_reg_addr_out;
    logic                  wb_write_enable_out;
    logic                  wb_valid_out;

    modport master (
        output result_in, reg_addr_in, mem_addr_in,
        output write_enable_in, store_enable_in, load_enable_in,
        input  stall_out, wb_data_out, wb_reg_addr_out,
        input  wb_write_enable_out, wb_valid_out
    );

    modport slave (
        input  result_in, reg_addr_in, mem_addr_in,
        input  write_enable_in, store_enable_in, load_enable_in,
        output stall_out, wb_data_out, wb_reg_addr_out,
        output wb_write_enable_out, wb_valid_out
    );
endinterface

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   Memory access + MEM/WB register. Performs stores/loads on a
//   2**ADDR_WIDTH x DATA_WIDTH data memory and presents registered writeback
//   signals. Loads take LOAD_LATENCY edges; while one is outstanding the
//   stage raises stall_out and ignores its inputs.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     bus    mem_wb_if.slave (EX/MEM inputs, MEM/WB outputs, stall)
//     load_count_out / store_count_out   (only with MEM_STATS_EN)
//
//   Optional feature macro: MEM_STATS_EN adds saturating 16-bit counters of
//   performed stores and completed (not aborted) loads.
// ---------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int LOAD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MEM_STATS_EN
    output logic [15:0] load_count_out,
    output logic [15:0] store_count_out,
`endif
    mem_wb_if.slave     bus
);
    localparam int       DEPTH  = 2 ** ADDR_WIDTH;
    localparam bit [3:0] LAT_M1 = 4'(LOAD_LATENCY - 1);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdData_q, rdData_d;
    logic [3:0]            latReg_q, latReg_d;
    logic                  latWe_q, latWe_d;
    logic [DATA_WIDTH-1:0] wbData_q, wbData_d;
    logic [3:0]            wbReg_q, wbReg_d;
    logic                  wbWe_q, wbWe_d;
    logic                  wbValid_q, wbValid_d;
    logic                  memWe;
    logic                  loadDone;

    // Next-state and writeback decode. Store wins over load; a load either
    // retires immediately (latency 1) or parks in LOAD_WAIT holding the word
    // read at accept time plus the latched destination, so the wait cycles
    // never look at the (held) inputs again.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdData_d  = rdData_q;
        latReg_d  = latReg_q;
        latWe_d   = latWe_q;
        wbData_d  = wbData_q;
        wbReg_d   = wbReg_q;
        wbWe_d    = 1'b0;
        wbValid_d = 1'b0;
        memWe     = 1'b0;
        loadDone  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.store_enable_in) begin
                    memWe     = 1'b1;
                    wbData_d  = bus.result_in;
                    wbReg_d   = bus.reg_addr_in;
                    wbWe_d    = bus.write_enable_in;
                    wbValid_d = 1'b1;
                end else if (bus.load_enable_in) begin
                    if (LOAD_LATENCY == 1) begin
                        wbData_d  = mem_q[bus.mem_addr_in];
                        wbReg_d   = bus.reg_addr_in;
                        wbWe_d    = bus.write_enable_in;
                        wbValid_d = 1'b1;
                        loadDone  = 1'b1;
                    end else begin
                        state_d  = LOAD_WAIT;
                        cnt_d    = LAT_M1;
                        rdData_d = mem_q[bus.mem_addr_in];
                        latReg_d = bus.reg_addr_in;
                        latWe_d  = bus.write_enable_in;
                    end
                end else if (bus.write_enable_in) begin
                    wbData_d  = bus.result_in;
                    wbReg_d   = bus.reg_addr_in;
                    wbWe_d    = 1'b1;
                    wbValid_d = 1'b1;
                end
            end
            LOAD_WAIT: begin
                if (cnt_q == 4'd1) begin
                    wbData_d  = rdData_q;
                    wbReg_d   = latReg_q;
                    wbWe_d    = latWe_q;
                    wbValid_d = 1'b1;
                    loadDone  = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pipeline state and data memory. Reset clears every memory word too,
    // and aborts any outstanding load without a writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rdData_q  <= '0;
            latReg_q  <= '0;
            latWe_q   <= 1'b0;
            wbData_q  <= '0;
            wbReg_q   <= '0;
            wbWe_q    <= 1'b0;
            wbValid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdData_q  <= rdData_d;
            latReg_q  <= latReg_d;
            latWe_q   <= latWe_d;
            wbData_q  <= wbData_d;
            wbReg_q   <= wbReg_d;
            wbWe_q    <= wbWe_d;
            wbValid_q <= wbValid_d;
            if (memWe) begin
                mem_q[bus.mem_addr_in] <= bus.result_in;
            end
        end
    end

`ifdef MEM_STATS_EN
    logic [15:0] loadCount_q, storeCount_q;

    // Saturating activity counters; a load only counts when it writes back.
    always_ff @(posedge clk) begin
        if (reset) begin
            loadCount_q  <= '0;
            storeCount_q <= '0;
        end else begin
            if (memWe && storeCount_q != 16'hFFFF) begin
                storeCount_q <= storeCount_q + 16'd1;
            end
            if (loadDone && loadCount_q != 16'hFFFF) begin
                loadCount_q <= loadCount_q + 16'd1;
            end
        end
    end

    assign load_count_out  = loadCount_q;
    assign store_count_out = storeCount_q;
`else
    logic unusedLoadDone;
    assign unusedLoadDone = loadDone;
`endif

    assign bus.stall_out           = (state_q == LOAD_WAIT);
    assign bus.wb_data_out         = wbData_q;
    assign bus.wb_reg_addr_out     = wbReg_q;
    assign bus.wb_write_enable_out = wbWe_q;
    assign bus.wb_valid_out        = wbValid_q;
endmodule
